// File: rtl/baccarat_pkg.sv
// Shared types, card constants and the card-to-point conversion used by the
// dealer and by the external score adders.
package baccarat_pkg;

  typedef enum logic [4:0] {
    IDLE, WAIT_P1, REQ_P1, WAIT_D1, REQ_D1, WAIT_P2, REQ_P2, WAIT_D2, REQ_D2,
    EVAL4, WAIT_P3, REQ_P3, EVAL_D3, WAIT_D3, REQ_D3, SCORE, DONE
  } state_t;

  localparam logic [3:0] CARD_EMPTY = 4'd0;
  localparam logic [3:0] CARD_MIN   = 4'd1;
  localparam logic [3:0] CARD_MAX   = 4'd13;
  localparam logic [3:0] FACE_MIN   = 4'd10;

  // Ten and face cards count zero; empty or illegal codes also count zero.
  function automatic logic [3:0] card_value(input logic [3:0] card);
    return (card >= CARD_MIN && card < FACE_MIN) ? card : 4'd0;
  endfunction

endpackage

// File: rtl/baccarat_dealer_if.sv
// Card source handshake: the dealer raises card_req, the source answers with
// card_valid and a card code.
interface baccarat_dealer_if;
  logic       card_req;
  logic       card_valid;
  logic [3:0] card_in;

  modport master (output card_req, input card_valid, input card_in);
  modport slave  (input card_req, output card_valid, output card_in);
endinterface

// File: rtl/dealer_draw_rule.sv
// Dealer third-card rule after the player has drawn, as a function of the
// dealer score and the point value of the player's third card.
module dealer_draw_rule (
  input  logic [3:0] i_dscore,
  input  logic [3:0] i_p3val,
  output logic       o_draw_d3
);

  always_comb begin
    o_draw_d3 = 1'b0;
    case (i_dscore)
      4'd0, 4'd1, 4'd2: o_draw_d3 = 1'b1;
      4'd3:             o_draw_d3 = (i_p3val != 4'd8);
      4'd4:             o_draw_d3 = (i_p3val >= 4'd2 && i_p3val <= 4'd7);
      4'd5:             o_draw_d3 = (i_p3val >= 4'd4 && i_p3val <= 4'd7);
      4'd6:             o_draw_d3 = (i_p3val >= 4'd6 && i_p3val <= 4'd7);
      default:          o_draw_d3 = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_dealer.sv
// Baccarat dealing engine: requests cards in standard order, applies naturals
// and third-card rules using the external hand scores, and flags the winner.
module baccarat_dealer
  import baccarat_pkg::*;
#(
  parameter logic [3:0] NATURAL_MIN     = 4'd8,
  parameter logic [3:0] PLAYER_DRAW_MAX = 4'd5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      deal_step,
  baccarat_dealer_if.master         bus,
  input  logic [3:0]                pscore,
  input  logic [3:0]                dscore,
  output logic [3:0]                pcard1,
  output logic [3:0]                pcard2,
  output logic [3:0]                pcard3,
  output logic [3:0]                dcard1,
  output logic [3:0]                dcard2,
  output logic [3:0]                dcard3,
  output logic                      busy,
  output logic                      done,
  output logic                      player_win,
  output logic                      dealer_win
);

  state_t     r_state;
  logic       r_card_req, r_busy, r_done, r_pwin, r_dwin;
  logic [3:0] r_pcard1, r_pcard2, r_pcard3, r_dcard1, r_dcard2, r_dcard3;
  logic       w_card_ok, w_draw_d3;
  logic [3:0] w_p3val;

  assign w_card_ok = bus.card_valid && bus.card_in >= CARD_MIN && bus.card_in <= CARD_MAX;
  assign w_p3val   = card_value(r_pcard3);

  dealer_draw_rule u_rule (
    .i_dscore  (dscore),
    .i_p3val   (w_p3val),
    .o_draw_d3 (w_draw_d3)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_card_req <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pwin     <= 1'b0;
      r_dwin     <= 1'b0;
      r_pcard1   <= CARD_EMPTY;
      r_pcard2   <= CARD_EMPTY;
      r_pcard3   <= CARD_EMPTY;
      r_dcard1   <= CARD_EMPTY;
      r_dcard2   <= CARD_EMPTY;
      r_dcard3   <= CARD_EMPTY;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= WAIT_P1;
          r_busy  <= 1'b1;
        end
        WAIT_P1: if (deal_step) begin r_state <= REQ_P1; r_card_req <= 1'b1; end
        REQ_P1:  if (w_card_ok) begin r_pcard1 <= bus.card_in; r_card_req <= 1'b0; r_state <= WAIT_D1; end
        WAIT_D1: if (deal_step) begin r_state <= REQ_D1; r_card_req <= 1'b1; end
        REQ_D1:  if (w_card_ok) begin r_dcard1 <= bus.card_in; r_card_req <= 1'b0; r_state <= WAIT_P2; end
        WAIT_P2: if (deal_step) begin r_state <= REQ_P2; r_card_req <= 1'b1; end
        REQ_P2:  if (w_card_ok) begin r_pcard2 <= bus.card_in; r_card_req <= 1'b0; r_state <= WAIT_D2; end
        WAIT_D2: if (deal_step) begin r_state <= REQ_D2; r_card_req <= 1'b1; end
        REQ_D2:  if (w_card_ok) begin r_dcard2 <= bus.card_in; r_card_req <= 1'b0; r_state <= EVAL4; end
        // Scores have settled on the four dealt cards by the end of this cycle.
        EVAL4: begin
          if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) r_state <= SCORE;
          else if (pscore <= PLAYER_DRAW_MAX)                 r_state <= WAIT_P3;
          else if (dscore <= 4'd5)                            r_state <= WAIT_D3;
          else                                                r_state <= SCORE;
        end
        WAIT_P3: if (deal_step) begin r_state <= REQ_P3; r_card_req <= 1'b1; end
        REQ_P3:  if (w_card_ok) begin r_pcard3 <= bus.card_in; r_card_req <= 1'b0; r_state <= EVAL_D3; end
        EVAL_D3: r_state <= w_draw_d3 ? WAIT_D3 : SCORE;
        WAIT_D3: if (deal_step) begin r_state <= REQ_D3; r_card_req <= 1'b1; end
        REQ_D3:  if (w_card_ok) begin r_dcard3 <= bus.card_in; r_card_req <= 1'b0; r_state <= SCORE; end
        SCORE: begin
          r_pwin  <= (pscore >= dscore);
          r_dwin  <= (dscore >= pscore);
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: if (deal_step) begin
          r_pcard1 <= CARD_EMPTY;
          r_pcard2 <= CARD_EMPTY;
          r_pcard3 <= CARD_EMPTY;
          r_dcard1 <= CARD_EMPTY;
          r_dcard2 <= CARD_EMPTY;
          r_dcard3 <= CARD_EMPTY;
          r_pwin   <= 1'b0;
          r_dwin   <= 1'b0;
          r_done   <= 1'b0;
          r_busy   <= 1'b1;
          r_state  <= WAIT_P1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.card_req = r_card_req;
  assign pcard1       = r_pcard1;
  assign pcard2       = r_pcard2;
  assign pcard3       = r_pcard3;
  assign dcard1       = r_dcard1;
  assign dcard2       = r_dcard2;
  assign dcard3       = r_dcard3;
  assign busy         = r_busy;
  assign done         = r_done;
  assign player_win   = r_pwin;
  assign dealer_win   = r_dwin;

endmodule

// File: tb/tb_baccarat_dealer.sv
// Bench for baccarat_dealer: a round-level baccarat model drives expectations,
// with the score adders modelled from the card outputs.
module tb_baccarat_dealer;

  typedef logic [5:0][3:0] shoe_t;  // [0]=P1 [1]=D1 [2]=P2 [3]=D2 [4],[5]=next cards
  typedef struct packed {
    shoe_t cards;  // expected register contents, same slot order, 4=P3 5=D3
    logic  pdraw;
    logic  ddraw;
    logic  pwin;
    logic  dwin;
  } res_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       deal_step = 1'b0;
  logic [3:0] pscore, dscore;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic       busy, done, player_win, dealer_win;
  logic [3:0] rs_d, rs_v;
  logic       rs_draw;

  baccarat_dealer_if bus();

  baccarat_dealer dut (
    .clock(clock), .reset(reset), .deal_step(deal_step), .bus(bus),
    .pscore(pscore), .dscore(dscore),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .busy(busy), .done(done), .player_win(player_win), .dealer_win(dealer_win)
  );

  dealer_draw_rule u_rule (.i_dscore(rs_d), .i_p3val(rs_v), .o_draw_d3(rs_draw));

  always #5 clock = ~clock;

  // Standard punto banco chart once the player has drawn: row = dealer score,
  // column = point value of the player's third card, D = dealer draws.
  string draw_tbl [8] = '{
    "DDDDDDDDDD", "DDDDDDDDDD", "DDDDDDDDDD", "DDDDDDDDSD",
    "SSDDDDDDSS", "SSSSDDDDSS", "SSSSSSDDSS", "SSSSSSSSSS"
  };

  function automatic int cv(input logic [3:0] c);
    return (c >= 1 && c <= 9) ? int'(c) : 0;
  endfunction

  function automatic shoe_t mk(input int a, b, c, d, e, f);
    shoe_t s;
    s[0] = 4'(a); s[1] = 4'(b); s[2] = 4'(c); s[3] = 4'(d); s[4] = 4'(e); s[5] = 4'(f);
    return s;
  endfunction

  function automatic res_t play(input shoe_t s);
    res_t r;
    int p, d, v, nxt;
    r = '0;
    for (int i = 0; i < 4; i++) r.cards[i] = s[i];
    p = (cv(s[0]) + cv(s[2])) % 10;
    d = (cv(s[1]) + cv(s[3])) % 10;
    nxt = 4;
    if (!(p >= 8 || d >= 8)) begin
      if (p <= 5) begin
        r.pdraw = 1'b1;
        r.cards[4] = s[4];
        v = cv(s[4]);
        p = (p + v) % 10;
        nxt = 5;
        r.ddraw = (draw_tbl[d][v] == "D");
      end else begin
        r.ddraw = (d <= 5);
      end
      if (r.ddraw) begin
        r.cards[5] = s[nxt];
        d = (d + cv(s[nxt])) % 10;
      end
    end
    r.pwin = (p >= d);
    r.dwin = (d >= p);
    return r;
  endfunction

  // External score adders
  always_comb begin
    pscore = 4'((cv(pcard1) + cv(pcard2) + cv(pcard3)) % 10);
    dscore = 4'((cv(dcard1) + cv(dcard2) + cv(dcard3)) % 10);
  end

  shoe_t exp_cards = '0;
  logic  exp_req = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_pw = 1'b0, exp_dw = 1'b0;
  bit    chk_en = 1'b0;
  int    n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("cards", 32'({dcard3, pcard3, dcard2, pcard2, dcard1, pcard1}), 32'(exp_cards));
      check("ctrl", 32'({bus.card_req, busy, done, player_win, dealer_win}),
            32'({exp_req, exp_busy, exp_done, exp_pw, exp_dw}));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic deal(input int slot, input logic [3:0] c);
    deal_step = 1'b1;
    step();
    deal_step = 1'b0;
    exp_req = 1'b1;
    bus.card_valid = 1'b1;
    bus.card_in = c;
    step();
    bus.card_valid = 1'b0;
    bus.card_in = 4'd0;
    exp_req = 1'b0;
    exp_cards[slot] = c;
  endtask

  task automatic run_round(input shoe_t s, input int first);
    res_t r;
    r = play(s);
    for (int i = first; i < 4; i++) deal(i, s[i]);
    step();
    if (r.pdraw) begin
      deal(4, r.cards[4]);
      step();
    end
    if (r.ddraw) deal(5, r.cards[5]);
    step();
    exp_busy = 1'b0;
    exp_done = 1'b1;
    exp_pw = r.pwin;
    exp_dw = r.dwin;
  endtask

  task automatic new_round();
    deal_step = 1'b1;
    step();
    deal_step = 1'b0;
    exp_cards = '0;
    exp_done = 1'b0;
    exp_busy = 1'b1;
    exp_pw = 1'b0;
    exp_dw = 1'b0;
  endtask

  task automatic lit_end(input string tag, input int p3, d3, pw, dw);
    check({tag, "_p3"}, 32'(pcard3), 32'(p3));
    check({tag, "_d3"}, 32'(dcard3), 32'(d3));
    check({tag, "_flags"}, 32'({done, player_win, dealer_win}), 32'({1'b1, 1'(pw), 1'(dw)}));
  endtask

  initial begin
    res_t m;
    bus.card_valid = 1'b0;
    bus.card_in = 4'd0;
    rs_d = 4'd0;
    rs_v = 4'd0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_cards", 32'({dcard3, pcard3, dcard2, pcard2, dcard1, pcard1}), 32'd0);
    check("rst_ctrl", 32'({bus.card_req, busy, done, player_win, dealer_win}), 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    step();
    exp_busy = 1'b1;

    // Model pins
    m = play(mk(2, 4, 3, 2, 5, 0));
    check("mdl_plan2", 32'({m.cards[4], m.cards[5], m.pwin, m.dwin}), 32'({4'd5, 4'd0, 1'b0, 1'b1}));
    m = play(mk(3, 1, 4, 2, 4, 0));
    check("mdl_plan3", 32'({m.cards[4], m.cards[5], m.pwin, m.dwin}), 32'({4'd0, 4'd4, 1'b1, 1'b1}));

    run_round(mk(8, 3, 13, 5, 0, 0), 0);     // naturals both 8: tie
    lit_end("natural", 0, 0, 1, 1);
    new_round();
    run_round(mk(2, 4, 3, 2, 5, 0), 0);      // player draws 5, dealer stands on 6
    lit_end("pdraw", 5, 0, 0, 1);
    new_round();
    run_round(mk(3, 1, 4, 2, 4, 0), 0);      // player stands 7, dealer 3 draws 4
    lit_end("ddraw", 0, 4, 1, 1);
    new_round();

    // Handshake: illegal codes and stray deal_step pulses in REQ_P1
    deal_step = 1'b1;
    step();
    exp_req = 1'b1;
    bus.card_valid = 1'b1;
    bus.card_in = 4'd0;
    step();
    bus.card_in = 4'd14;
    step();
    bus.card_in = 4'd15;
    deal_step = 1'b0;
    step();
    check("hs_hold", 32'({bus.card_req, pcard1}), 32'({1'b1, 4'd0}));
    bus.card_in = 4'd9;
    deal_step = 1'b1;
    step();
    exp_cards[0] = 4'd9;
    exp_req = 1'b0;
    deal_step = 1'b0;
    bus.card_in = 4'd5;                      // valid while card_req low: ignored
    step();
    bus.card_valid = 1'b0;
    bus.card_in = 4'd0;
    check("hs_load", 32'({bus.card_req, pcard1, dcard1}), 32'({1'b0, 4'd9, 4'd0}));
    run_round(mk(9, 12, 7, 13, 6, 0), 1);
    lit_end("hs", 0, 6, 1, 1);
    new_round();

    run_round(mk(1, 10, 1, 3, 8, 0), 0);     // dealer 3 stands on player third 8
    lit_end("d3v8", 8, 0, 0, 1);
    new_round();
    run_round(mk(4, 5, 13, 13, 6, 3), 0);    // dealer 5 draws on player third 6
    lit_end("d5v6", 6, 3, 0, 1);
    new_round();

    // Asynchronous reset in REQ_D2 with three cards loaded
    deal(0, 4'd5);
    deal(1, 4'd6);
    deal(2, 4'd7);
    deal_step = 1'b1;
    step();
    deal_step = 1'b0;
    exp_req = 1'b1;
    #2;
    reset = 1'b1;
    exp_cards = '0;
    exp_req = 1'b0;
    exp_busy = 1'b0;
    #1;
    check("arst_cards", 32'({dcard3, pcard3, dcard2, pcard2, dcard1, pcard1}), 32'd0);
    check("arst_ctrl", 32'({bus.card_req, busy, done, player_win, dealer_win}), 32'd0);
    step();
    reset = 1'b0;
    step();
    exp_busy = 1'b1;
    check("arst_wait_p1", 32'({busy, done}), 32'({1'b1, 1'b0}));
    run_round(mk(2, 7, 10, 11, 6, 0), 0);    // player 8 beats dealer 7
    lit_end("after_rst", 6, 0, 1, 0);
    chk_en = 1'b0;

    // Rule table sweep on the stand-alone rule block
    for (int d = 0; d < 8; d++) begin
      for (int v = 0; v < 10; v++) begin
        rs_d = 4'(d);
        rs_v = 4'(v);
        #1;
        check($sformatf("rule_d%0d_v%0d", d, v), 32'(rs_draw), 32'(draw_tbl[d][v] == "D"));
      end
    end
    rs_d = 4'd3; rs_v = 4'd8; #1;
    check("rule_lit_d3v8", 32'(rs_draw), 32'd0);
    rs_d = 4'd6; rs_v = 4'd7; #1;
    check("rule_lit_d6v7", 32'(rs_draw), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
